// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the LED sequence presenter: state codes and
// default on/off times.
package exibe_sequencia_pkg;

    localparam int T_ON_DEFAULT  = 50;
    localparam int T_OFF_DEFAULT = 25;

    // Codes are exactly what appears on db_estado for the debug display.
    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PREPARA = 4'd1,
        ACENDE  = 4'd2,
        APAGA   = 4'd3,
        PROXIMO = 4'd4,
        FIM     = 4'd15
    } estado_t;

endpackage

// File: rtl/exibe_sequencia_temporizador.sv
// Cycle timer: counts enabled cycles after a clear and raises fim_contagem
// on the LIMIT-th cycle, then holds there until cleared.
module temporizador #(
    parameter int LIMIT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim_contagem
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count_reg <= '0;
        end else if (enable && !fim_contagem) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign fim_contagem = (count_reg == W'(LIMIT - 1));

endmodule

// File: rtl/exibe_sequencia.sv
// Presents plays 0..limite from a synchronous sequence memory on the LEDs,
// each lit for T_ON cycles followed by a T_OFF dark gap, then pulses pronto.
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int T_ON  = T_ON_DEFAULT,
    parameter int T_OFF = T_OFF_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       pronto,
    output logic [3:0] db_estado
);

    estado_t    state_reg, state_next;
    logic [3:0] endereco_reg, endereco_next;
    logic [3:0] limite_reg, limite_next;
    logic       fim_on, fim_off;

    temporizador #(.LIMIT(T_ON)) u_tempo_on (
        .clock        (clock),
        .reset        (reset),
        .clear        (state_reg != ACENDE),
        .enable       (state_reg == ACENDE),
        .fim_contagem (fim_on)
    );

    temporizador #(.LIMIT(T_OFF)) u_tempo_off (
        .clock        (clock),
        .reset        (reset),
        .clear        (state_reg != APAGA),
        .enable       (state_reg == APAGA),
        .fim_contagem (fim_off)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= INICIAL;
            endereco_reg <= '0;
            limite_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            endereco_reg <= endereco_next;
            limite_reg   <= limite_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        endereco_next = endereco_reg;
        limite_next   = limite_reg;
        case (state_reg)
            INICIAL: begin
                if (iniciar) begin
                    state_next    = PREPARA;
                    endereco_next = '0;
                    limite_next   = limite;
                end
            end
            // One cycle for the memory to return dado for endereco.
            PREPARA: state_next = ACENDE;
            ACENDE:  if (fim_on) state_next = APAGA;
            APAGA: begin
                if (fim_off) begin
                    state_next = (endereco_reg == limite_reg) ? FIM : PROXIMO;
                end
            end
            PROXIMO: begin
                endereco_next = endereco_reg + 4'd1;
                state_next    = PREPARA;
            end
            FIM:     state_next = INICIAL;
            default: state_next = INICIAL;
        endcase
    end

    // dado is already the memory's output register; gating it by the
    // registered state keeps leds exact for the whole ACENDE window.
    assign leds      = (state_reg == ACENDE) ? dado : 4'b0000;
    assign pronto    = (state_reg == FIM);
    assign endereco  = endereco_reg;
    assign db_estado = state_reg;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Randomized self-checking bench for exibe_sequencia with T_ON=3, T_OFF=2
// against a cycle-position model of the presentation timeline.
module tb_exibe_sequencia;

    localparam int T_ON  = 3;
    localparam int T_OFF = 2;
    localparam int P     = T_ON + T_OFF + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] limite = 4'd0;
    logic [3:0] dado = 4'd0;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] mem [16];

    int total = 0;
    int bad   = 0;

    exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .limite    (limite),
        .dado      (dado),
        .endereco  (endereco),
        .leds      (leds),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Sequence memory with one cycle of read latency.
    always @(posedge clock) dado <= mem[endereco];

    // Expected outputs c cycles after the edge that sampled iniciar.
    function automatic void model(input int lim, input int c,
                                  output logic [3:0] st, output logic [3:0] ld,
                                  output logic [3:0] en, output logic pr);
        int n, k, r;
        n  = (lim + 1) * P + lim;
        st = 4'd0; ld = 4'd0; pr = 1'b0; en = lim[3:0];
        if (c == n) begin
            st = 4'd15; pr = 1'b1;
        end else if (c < n) begin
            k  = c / (P + 1);
            r  = c % (P + 1);
            en = k[3:0];
            if (r == 0)           st = 4'd1;
            else if (r <= T_ON) begin st = 4'd2; ld = mem[k]; end
            else if (r < P)       st = 4'd3;
            else                  st = 4'd4;
        end
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_cycle(input string tag, input int lim, input int c);
        logic [3:0] est, eld, een;
        logic       epr;
        model(lim, c, est, eld, een, epr);
        total += 4;
        if (db_estado !== est) begin
            bad++; $display("FAIL %s c=%0d db_estado got=%0d want=%0d", tag, c, db_estado, est);
        end
        if (leds !== eld) begin
            bad++; $display("FAIL %s c=%0d leds got=%b want=%b", tag, c, leds, eld);
        end
        if (endereco !== een) begin
            bad++; $display("FAIL %s c=%0d endereco got=%0d want=%0d", tag, c, endereco, een);
        end
        if (pronto !== epr) begin
            bad++; $display("FAIL %s c=%0d pronto got=%b want=%b", tag, c, pronto, epr);
        end
    endtask

    task automatic check_idle(input string tag);
        total += 4;
        if (db_estado !== 4'd0) begin bad++; $display("FAIL %s db_estado got=%0d want=0", tag, db_estado); end
        if (leds !== 4'd0)      begin bad++; $display("FAIL %s leds got=%b want=0000", tag, leds); end
        if (endereco !== 4'd0)  begin bad++; $display("FAIL %s endereco got=%0d want=0", tag, endereco); end
        if (pronto !== 1'b0)    begin bad++; $display("FAIL %s pronto got=%b want=0", tag, pronto); end
    endtask

    // One full presentation; hold keeps iniciar high, disturb pokes inputs in APAGA.
    task automatic run_seq(input string tag, input int lim, input bit hold, input bit disturb);
        int n;
        logic [3:0] est, eld, een;
        logic       epr;
        n = (lim + 1) * P + lim;
        limite  = lim[3:0];
        iniciar = 1'b1;
        step();
        if (!hold) iniciar = 1'b0;
        for (int c = 0; c <= n + 1; c++) begin
            check_cycle(tag, lim, c);
            model(lim, c, est, eld, een, epr);
            if (disturb && est == 4'd3) begin
                iniciar = 1'b1;
                limite  = 4'($urandom_range(0, 15));
            end else begin
                iniciar = hold;
            end
            if (c <= n) step();
        end
        $display("%s: limite=%0d hold=%0b disturb=%0b pronto_at=%0d", tag, lim, hold, disturb, n);
    endtask

    task automatic test_reset();
        reset = 1'b0; iniciar = 1'b1; limite = 4'd7;
        step(); step();
        check_idle("reset_priority");
        iniciar = 1'b0; reset = 1'b1;
        step();
        check_idle("reset_release");
        $display("test_reset: done");
    endtask

    task automatic do_reset();
        iniciar = 1'b0; reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_acende();
        int c_hit;
        c_hit = 2 * (P + 1) + 2;
        limite = 4'd3; iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        for (int c = 0; c <= c_hit; c++) begin
            check_cycle("mid_reset_pre", 3, c);
            if (c < c_hit) step();
        end
        reset = 1'b0;
        step();
        check_idle("mid_reset_edge");
        reset = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            total++;
            if (pronto !== 1'b0 || db_estado !== 4'd0) begin
                bad++; $display("FAIL mid_reset_after c=%0d pronto=%b db_estado=%0d want 0/0", c, pronto, db_estado);
            end
        end
        $display("test_reset_mid_acende: reset at c=%0d", c_hit);
    endtask

    task automatic test_hold();
        int n;
        n = (2 + 1) * P + 2;
        run_seq("hold", 2, 1'b1, 1'b0);
        step();
        total++;
        if (db_estado !== 4'd1) begin
            bad++; $display("FAIL hold_restart db_estado got=%0d want=1", db_estado);
        end
        $display("test_hold: restart observed at c=%0d", n + 2);
        do_reset();
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
            run_seq("random", $urandom_range(0, 5), 1'b0, t[0]);
        end
        for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
        test_reset();
        run_seq("limite0", 0, 1'b0, 1'b0);
        run_seq("limite3", 3, 1'b0, 1'b0);
        run_seq("limite15", 15, 1'b0, 1'b0);
        test_reset_mid_acende();
        run_seq("disturb", 3, 1'b0, 1'b1);
        test_hold();
        test_random();
        run_seq("back_to_back_a", 1, 1'b0, 1'b0);
        run_seq("back_to_back_b", 2, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
